vend_seq_ctrl: RTL

VEND_SEQ_CTRL -- requirements
Module: vend_seq_ctrl

---
 rtl/vend_pkg.sv | 20 ++
 rtl/vend_change_ejector.sv | 29 ++
 rtl/vend_seq_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: FSM states, accepted coin values
// and the denominations the change ejector can pay out.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DISPENSE,
    ST_CHANGE,
    ST_REFUND
  } vend_state_t;

  localparam int unsigned NICKEL_CENTS  = 5;
  localparam int unsigned DIME_CENTS    = 10;
  localparam int unsigned QUARTER_CENTS = 25;

  localparam int unsigned CHG_DIME_CENTS   = 10;
  localparam int unsigned CHG_NICKEL_CENTS = 5;

endpackage

// File: rtl/vend_change_ejector.sv
// Greedy coin ejector: offers a dime while credit >= 10, else a nickel, and reports
// the accepted ejection plus the credit left after it.
module vend_change_ejector
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 6
) (
  input  logic                active,
  input  logic [CREDIT_W-1:0] credit,
  input  logic                chg_ready,
  output logic                chg_valid,
  output logic                chg_dime,
  output logic                take,
  output logic [CREDIT_W-1:0] credit_nxt
);

  localparam logic [CREDIT_W-1:0] DIME_V   = CREDIT_W'(CHG_DIME_CENTS);
  localparam logic [CREDIT_W-1:0] NICKEL_V = CREDIT_W'(CHG_NICKEL_CENTS);

  // Driven only from registered state and credit, so valid/type cannot move
  // while the ejector stalls on ready.
  always_comb begin
    chg_valid  = active && (credit != '0);
    chg_dime   = chg_valid && (credit >= DIME_V);
    take       = chg_valid && chg_ready;
    credit_nxt = credit - (chg_dime ? DIME_V : NICKEL_V);
  end

endmodule

// File: rtl/vend_seq_ctrl.sv
// Vending machine sequencer: collects coins, dispenses at PRICE, then returns
// change or refunds through the shared change ejector.
module vend_seq_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE    = 20,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CREDIT_W = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_nickle,
  input  logic                i_dime,
  input  logic                i_quarter,
  input  logic                i_cancel,
  output logic                o_disp_req,
  input  logic                i_disp_ack,
  output logic                o_chg_valid,
  output logic                o_chg_dime,
  input  logic                i_chg_ready,
  output logic                o_coin_reject,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_busy
);

  localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [TO_W-1:0]     TO_LAST  = TO_W'(TIMEOUT - 1);

  vend_state_t         state;
  logic [CREDIT_W-1:0] credit;
  logic [TO_W-1:0]     to_cnt;
  logic                coin_rej_q;

  logic [1:0]          coin_cnt;
  logic                coin_one;
  logic                coin_ok;
  logic                reject_nxt;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] credit_add;
  logic                busy;
  logic                ej_active;
  logic                ej_take;
  logic [CREDIT_W-1:0] ej_credit_nxt;

  always_comb begin
    coin_cnt   = 2'(i_nickle) + 2'(i_dime) + 2'(i_quarter);
    coin_one   = (coin_cnt == 2'd1);
    busy       = !((state == ST_IDLE) || (state == ST_COLLECT));
    coin_ok    = coin_one && !busy;
    reject_nxt = (coin_cnt > 2'd1) || (coin_one && busy);
    coin_val   = '0;
    if (i_nickle)       coin_val = CREDIT_W'(NICKEL_CENTS);
    else if (i_dime)    coin_val = CREDIT_W'(DIME_CENTS);
    else if (i_quarter) coin_val = CREDIT_W'(QUARTER_CENTS);
    credit_add = credit + coin_val;
    ej_active  = (state == ST_CHANGE) || (state == ST_REFUND);
  end

  vend_change_ejector #(
    .CREDIT_W (CREDIT_W)
  ) u_ejector (
    .active     (ej_active),
    .credit     (credit),
    .chg_ready  (i_chg_ready),
    .chg_valid  (o_chg_valid),
    .chg_dime   (o_chg_dime),
    .take       (ej_take),
    .credit_nxt (ej_credit_nxt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      credit     <= '0;
      to_cnt     <= '0;
      coin_rej_q <= 1'b0;
    end else begin
      coin_rej_q <= reject_nxt;
      case (state)
        ST_IDLE: begin
          if (coin_ok) begin
            credit <= credit_add;
            to_cnt <= '0;
            state  <= ST_COLLECT;
          end
        end
        // A coin is credited before cancel is considered; cancel only wins below PRICE.
        ST_COLLECT: begin
          if (coin_ok) begin
            credit <= credit_add;
            to_cnt <= '0;
            if (credit_add >= PRICE_C) state <= ST_DISPENSE;
            else if (i_cancel)         state <= ST_REFUND;
          end else if (credit >= PRICE_C) begin
            state <= ST_DISPENSE;
          end else if (i_cancel) begin
            to_cnt <= '0;
            state  <= ST_REFUND;
          end else if (to_cnt == TO_LAST) begin
            to_cnt <= '0;
            state  <= ST_REFUND;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DISPENSE: begin
          if (i_disp_ack) begin
            credit <= credit - PRICE_C;
            state  <= (credit == PRICE_C) ? ST_IDLE : ST_CHANGE;
          end
        end
        ST_CHANGE, ST_REFUND: begin
          if (credit == '0) begin
            state <= ST_IDLE;
          end else if (ej_take) begin
            credit <= ej_credit_nxt;
            if (ej_credit_nxt == '0) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_disp_req    = (state == ST_DISPENSE);
  assign o_busy        = busy;
  assign o_coin_reject = coin_rej_q;
  assign o_credit      = credit;

endmodule
